// File: rtl/fft_frame_serializer.sv
// Parallel-to-serial output stage: captures 16-bin FFT frames and streams them one word per
// valid/ready beat, with one extra frame of buffering so a new result can land while draining.
module fft_frame_serializer #(
  parameter int DW     = 32,
  parameter bit BITREV = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fft_valid,
  input  logic [DW-1:0] fft_d0,
  input  logic [DW-1:0] fft_d1,
  input  logic [DW-1:0] fft_d2,
  input  logic [DW-1:0] fft_d3,
  input  logic [DW-1:0] fft_d4,
  input  logic [DW-1:0] fft_d5,
  input  logic [DW-1:0] fft_d6,
  input  logic [DW-1:0] fft_d7,
  input  logic [DW-1:0] fft_d8,
  input  logic [DW-1:0] fft_d9,
  input  logic [DW-1:0] fft_d10,
  input  logic [DW-1:0] fft_d11,
  input  logic [DW-1:0] fft_d12,
  input  logic [DW-1:0] fft_d13,
  input  logic [DW-1:0] fft_d14,
  input  logic [DW-1:0] fft_d15,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_d,
  output logic [3:0]    out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
);

  // Handshake: a word moves when out_valid and out_ready are both high at a rising edge;
  // while out_valid is high and out_ready is low, out_d/out_idx/out_last hold steady.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]    state, state_n;
  logic [DW-1:0] in_frame [16];
  logic [DW-1:0] active   [16];
  logic [DW-1:0] pending  [16];
  logic [3:0]    cnt, cnt_n, slot;
  logic          pend_full, pend_full_n;
  logic          load_act_in, load_act_pend, load_pend, ovf_n;
  logic          send, xfer, last_xfer;

  assign in_frame[0]  = fft_d0;
  assign in_frame[1]  = fft_d1;
  assign in_frame[2]  = fft_d2;
  assign in_frame[3]  = fft_d3;
  assign in_frame[4]  = fft_d4;
  assign in_frame[5]  = fft_d5;
  assign in_frame[6]  = fft_d6;
  assign in_frame[7]  = fft_d7;
  assign in_frame[8]  = fft_d8;
  assign in_frame[9]  = fft_d9;
  assign in_frame[10] = fft_d10;
  assign in_frame[11] = fft_d11;
  assign in_frame[12] = fft_d12;
  assign in_frame[13] = fft_d13;
  assign in_frame[14] = fft_d14;
  assign in_frame[15] = fft_d15;

  assign send      = (state == S_SEND);
  assign xfer      = send & out_ready;
  assign last_xfer = xfer & (cnt == 4'd15);
  assign slot      = BITREV ? {cnt[0], cnt[1], cnt[2], cnt[3]} : cnt;

  assign out_valid = send;
  assign out_d     = send ? active[slot] : '0;
  assign out_idx   = send ? slot : 4'd0;
  assign out_last  = send & (cnt == 4'd15);

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    pend_full_n   = pend_full;
    load_act_in   = 1'b0;
    load_act_pend = 1'b0;
    load_pend     = 1'b0;
    ovf_n         = 1'b0;
    if (!send) begin
      if (fft_valid) begin
        load_act_in = 1'b1;
        cnt_n       = 4'd0;
        state_n     = S_SEND;
      end
    end else if (last_xfer) begin
      // Frame boundary: refill from pending first, else straight from the input, else go idle.
      cnt_n = 4'd0;
      if (pend_full) begin
        load_act_pend = 1'b1;
        if (fft_valid) load_pend = 1'b1;
        else           pend_full_n = 1'b0;
      end else if (fft_valid) begin
        load_act_in = 1'b1;
      end else begin
        state_n = S_IDLE;
      end
    end else begin
      if (xfer) cnt_n = cnt + 4'd1;
      if (fft_valid) begin
        if (!pend_full) begin
          load_pend   = 1'b1;
          pend_full_n = 1'b1;
        end else begin
          ovf_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      pend_full <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        active[i]  <= '0;
        pending[i] <= '0;
      end
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pend_full <= pend_full_n;
      busy      <= (state_n == S_SEND) | pend_full_n;
      overflow  <= ovf_n;
      for (int i = 0; i < 16; i++) begin
        if (load_act_in)        active[i] <= in_frame[i];
        else if (load_act_pend) active[i] <= pending[i];
        if (load_pend)          pending[i] <= in_frame[i];
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Bench for fft_frame_serializer: natural-order and bit-reversed instances share stimulus and
// are checked each cycle against a frame-queue reference model.
module tb_fft_frame_serializer;
  localparam int DW = 32;
  typedef logic [16*DW-1:0] frame_t;

  logic   clk = 1'b0;
  logic   rst;
  logic   fft_valid;
  logic   out_ready;
  frame_t fin;

  logic          v0, l0, b0, o0, v1, l1, b1, o1;
  logic [DW-1:0] d0, d1;
  logic [3:0]    i0, i1;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: frames held (head is the one being streamed), beat within head frame.
  frame_t held_q[$];
  int     m_cnt;
  bit     m_ovf;

  always #5 clk = ~clk;

  fft_frame_serializer #(.DW(DW), .BITREV(1'b0)) dut_nat (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fin[0*DW +: DW]),   .fft_d1(fin[1*DW +: DW]),   .fft_d2(fin[2*DW +: DW]),
    .fft_d3(fin[3*DW +: DW]),   .fft_d4(fin[4*DW +: DW]),   .fft_d5(fin[5*DW +: DW]),
    .fft_d6(fin[6*DW +: DW]),   .fft_d7(fin[7*DW +: DW]),   .fft_d8(fin[8*DW +: DW]),
    .fft_d9(fin[9*DW +: DW]),   .fft_d10(fin[10*DW +: DW]), .fft_d11(fin[11*DW +: DW]),
    .fft_d12(fin[12*DW +: DW]), .fft_d13(fin[13*DW +: DW]), .fft_d14(fin[14*DW +: DW]),
    .fft_d15(fin[15*DW +: DW]),
    .out_ready(out_ready), .out_valid(v0), .out_d(d0), .out_idx(i0), .out_last(l0),
    .busy(b0), .overflow(o0)
  );

  fft_frame_serializer #(.DW(DW), .BITREV(1'b1)) dut_rev (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fin[0*DW +: DW]),   .fft_d1(fin[1*DW +: DW]),   .fft_d2(fin[2*DW +: DW]),
    .fft_d3(fin[3*DW +: DW]),   .fft_d4(fin[4*DW +: DW]),   .fft_d5(fin[5*DW +: DW]),
    .fft_d6(fin[6*DW +: DW]),   .fft_d7(fin[7*DW +: DW]),   .fft_d8(fin[8*DW +: DW]),
    .fft_d9(fin[9*DW +: DW]),   .fft_d10(fin[10*DW +: DW]), .fft_d11(fin[11*DW +: DW]),
    .fft_d12(fin[12*DW +: DW]), .fft_d13(fin[13*DW +: DW]), .fft_d14(fin[14*DW +: DW]),
    .fft_d15(fin[15*DW +: DW]),
    .out_ready(out_ready), .out_valid(v1), .out_d(d1), .out_idx(i1), .out_last(l1),
    .busy(b1), .overflow(o1)
  );

  function automatic int rev4(input int v);
    int r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((v >> b) & 1);
    return r;
  endfunction

  function automatic frame_t ramp_frame();
    frame_t f;
    for (int k = 0; k < 16; k++) f[k*DW +: DW] = 32'h0001_0000 * k + k;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < 16; k++) f[k*DW +: DW] = $urandom;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic          ev;
    logic [DW-1:0] ed0, ed1;
    int            ix0, ix1;
    ev  = (held_q.size() > 0);
    ix0 = ev ? m_cnt : 0;
    ix1 = ev ? rev4(m_cnt) : 0;
    ed0 = ev ? held_q[0][ix0*DW +: DW] : '0;
    ed1 = ev ? held_q[0][ix1*DW +: DW] : '0;
    chk("nat_valid", v0, ev);
    chk("nat_d", d0, ed0);
    chk("nat_idx", i0, ix0);
    chk("nat_last", l0, ev && m_cnt == 15);
    chk("nat_busy", b0, ev);
    chk("nat_ovf", o0, m_ovf);
    chk("rev_valid", v1, ev);
    chk("rev_d", d1, ed1);
    chk("rev_idx", i1, ix1);
    chk("rev_last", l1, ev && m_cnt == 15);
    chk("rev_busy", b1, ev);
    chk("rev_ovf", o1, m_ovf);
  endtask

  task automatic model_clear();
    held_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input bit fv, input bit rdy, input frame_t f);
    if (!rst) begin
      model_clear();
    end else begin
      m_ovf = 1'b0;
      if (held_q.size() > 0 && rdy) begin
        if (m_cnt == 15) begin
          void'(held_q.pop_front());
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (fv) begin
        if (held_q.size() < 2) held_q.push_back(f);
        else                   m_ovf = 1'b1;
      end
    end
  endtask

  // Check outputs for the current cycle, then drive inputs for the coming edge.
  task automatic step(input bit fv, input bit rdy, input frame_t f);
    check_all();
    fft_valid = fv;
    out_ready = rdy;
    fin       = f;
    @(posedge clk);
    model_edge(fv, rdy, f);
    @(negedge clk);
    fft_valid = 1'b0;
  endtask

  task automatic idle_steps(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, fin);
  endtask

  initial begin
    rst       = 1'b0;
    fft_valid = 1'b0;
    out_ready = 1'b0;
    fin       = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
    idle_steps(2, 1'b1);

    // Single frame, natural and bit-reversed order, ready tied high.
    step(1'b1, 1'b1, ramp_frame());
    idle_steps(20, 1'b1);

    // Backpressure at beat 3 for 5 cycles.
    step(1'b1, 1'b1, rand_frame());
    idle_steps(3, 1'b1);
    idle_steps(5, 1'b0);
    idle_steps(20, 1'b1);

    // Back-to-back: B at A's beat 7, C on A's last transfer.
    step(1'b1, 1'b1, rand_frame());
    idle_steps(7, 1'b1);
    step(1'b1, 1'b1, rand_frame());
    idle_steps(7, 1'b1);
    step(1'b1, 1'b1, rand_frame());
    idle_steps(40, 1'b1);

    // Overflow: three strobes while stalled; C must be dropped.
    step(1'b1, 1'b0, rand_frame());
    step(1'b1, 1'b0, rand_frame());
    step(1'b1, 1'b0, rand_frame());
    idle_steps(4, 1'b0);
    idle_steps(40, 1'b1);

    // Reset at beat 9 with a pending frame held.
    step(1'b1, 1'b1, rand_frame());
    step(1'b1, 1'b1, rand_frame());
    idle_steps(8, 1'b1);
    rst = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    idle_steps(3, 1'b1);
    rst = 1'b1;
    idle_steps(5, 1'b1);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, rand_frame());
    end
    idle_steps(40, 1'b1);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
